// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: synchronizes raw lines, turns level/edge events into
// single-cycle request pulses for the PLIC core and blocks re-requests until int_end.
module plic_gateway #(
    parameter int NSRC        = 128,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_CNT_W  = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] irq_src,
    input  logic [NSRC-1:0] edge_sel,
    input  logic [NSRC-1:0] int_end,
    output logic [NSRC-1:0] int_req_pack,
    output logic            gateway_notif,
    output logic [NSRC-1:0] inflight
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

    logic [NSRC-1:0]       sync_q [SYNC_STAGES];
    logic [NSRC-1:0]       prev_q;
    logic [NSRC-1:0]       state_q, state_d;
    logic [NSRC-1:0]       req_q, req_d;
    logic                  notif_q;
    logic [EDGE_CNT_W-1:0] cnt_q [NSRC];
    logic [EDGE_CNT_W-1:0] cnt_d [NSRC];

    logic [NSRC-1:0] s;
    logic [NSRC-1:0] trig;

    assign s    = sync_q[SYNC_STAGES-1];
    // Level mode triggers on s; edge mode masks it with the previous sample.
    assign trig = s & ~(edge_sel & prev_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        req_d   = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < NSRC; i++) begin
            if (state_q[i] == ST_IDLE) begin
                if (trig[i]) begin
                    req_d[i]   = 1'b1;
                    state_d[i] = ST_WAIT;
                end
            end else if (!int_end[i]) begin
                if (edge_sel[i] && trig[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (!edge_sel[i]) begin
                if (s[i]) begin
                    req_d[i] = 1'b1;
                end else begin
                    state_d[i] = ST_IDLE;
                end
            end else if (cnt_q[i] != '0) begin
                // A new edge arriving with the completion replaces the one consumed.
                req_d[i] = 1'b1;
                if (!trig[i]) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end else if (trig[i]) begin
                req_d[i] = 1'b1;
            end else begin
                state_d[i] = ST_IDLE;
            end
            if (!edge_sel[i]) begin
                cnt_d[i] = '0;
            end
        end
        // Source 0 is reserved and never requests.
        req_d[0]   = 1'b0;
        state_d[0] = ST_IDLE;
        cnt_d[0]   = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q  <= '0;
            state_q <= {NSRC{ST_IDLE}};
            req_q   <= '0;
            notif_q <= 1'b0;
            // NOTE: the edge counters are architectural state, so the array is cleared on reset.
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q  <= s;
            state_q <= state_d;
            req_q   <= req_d;
            notif_q <= |req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign int_req_pack  = req_q;
    assign gateway_notif = notif_q;
    assign inflight      = state_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Scoreboard bench for plic_gateway: directed stimulus pushes expected request pulses
// (cycle + packed bits); a negedge monitor pops and compares whatever the DUT emits.
module tb_plic_gateway;

    localparam int NSRC = 128;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] edge_sel;
    logic [NSRC-1:0] int_end;
    logic [NSRC-1:0] int_req_pack;
    logic            gateway_notif;
    logic [NSRC-1:0] inflight;

    typedef struct {
        int              cyc;
        logic [NSRC-1:0] pack;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    plic_gateway #(.NSRC(NSRC), .SYNC_STAGES(2), .EDGE_CNT_W(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .irq_src      (irq_src),
        .edge_sel     (edge_sel),
        .int_end      (int_end),
        .int_req_pack (int_req_pack),
        .gateway_notif(gateway_notif),
        .inflight     (inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NSRC-1:0] act, input logic [NSRC-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Advance so that inputs driven next are sampled at edge e.
    task automatic goto(input int e);
        while (cyc < e - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input int c, input logic [NSRC-1:0] p);
        exp_t e;
        e.cyc  = c;
        e.pack = p;
        exp_q.push_back(e);
    endtask

    function automatic logic [NSRC-1:0] bitv(input int i);
        logic [NSRC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: outputs are stable between edges, so sample on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        n_cmp++;
        if (gateway_notif !== (|int_req_pack)) begin
            n_fail++;
            $display("FAIL notif_vs_pack @cyc %0d: notif %b pack %h", cyc, gateway_notif, int_req_pack);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL missed_pulse: expected %h at cyc %0d, no pulse observed", e.pack, e.cyc);
        end
        if (gateway_notif !== 1'b0 || int_req_pack !== '0) begin
            n_cmp++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL unexpected_pulse @cyc %0d: got %h expected none", cyc, int_req_pack);
            end else begin
                e = exp_q.pop_front();
                if (int_req_pack !== e.pack) begin
                    n_fail++;
                    $display("FAIL pulse_bits @cyc %0d: got %h expected %h", cyc, int_req_pack, e.pack);
                end
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        irq_src  = '0;
        edge_sel = '0;
        int_end  = '0;
        edge_sel[40] = 1'b1;
        edge_sel[9]  = 1'b1;
        edge_sel[20] = 1'b1;

        // Reset state
        goto(3);
        check("reset_pack", int_req_pack, '0);
        check("reset_notif", NSRC'(gateway_notif), '0);
        check("reset_inflight", inflight, '0);
        goto(4);
        rstn = 1'b1;

        // Level request and clear on source 5
        goto(10); irq_src[5] = 1'b1; expect_pulse(12, bitv(5));
        goto(11); irq_src[5] = 1'b0;
        goto(16); check("lvl_inflight_set", inflight, bitv(5));
        goto(20); int_end[5] = 1'b1;
        goto(21); int_end[5] = 1'b0;
        check("lvl_inflight_clr", inflight, '0);

        // Level re-request: line still high at completion
        goto(30); irq_src[5] = 1'b1; expect_pulse(32, bitv(5));
        goto(40); int_end[5] = 1'b1; expect_pulse(40, bitv(5));
        goto(41); int_end[5] = 1'b0;
        check("lvl_rereq_inflight", inflight, bitv(5));
        goto(42); irq_src[5] = 1'b0;
        goto(50); int_end[5] = 1'b1;
        goto(51); int_end[5] = 1'b0;
        check("lvl_final_idle", inflight, '0);

        // Edge queuing on source 40: first edge requests, five more saturate cnt at 3
        goto(60); irq_src[40] = 1'b1; expect_pulse(62, bitv(40));
        goto(61); irq_src[40] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            goto(64 + 2 * k); irq_src[40] = 1'b1;
            goto(65 + 2 * k); irq_src[40] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            goto(80 + 4 * k); int_end[40] = 1'b1;
            if (k < 3) expect_pulse(80 + 4 * k, bitv(40));
            goto(81 + 4 * k); int_end[40] = 1'b0;
            if (k == 2) check("edge_still_wait", inflight, bitv(40));
        end
        check("edge_drained_idle", inflight, '0);

        // Simultaneous sources including reserved source 0
        goto(100);
        irq_src[0] = 1'b1; irq_src[1] = 1'b1; irq_src[64] = 1'b1; irq_src[127] = 1'b1;
        expect_pulse(102, bitv(1) | bitv(64) | bitv(127));
        goto(101); irq_src = '0;
        goto(106); check("multi_inflight", inflight, bitv(1) | bitv(64) | bitv(127));
        goto(110); int_end[0] = 1'b1; int_end[1] = 1'b1; int_end[64] = 1'b1; int_end[127] = 1'b1;
        goto(111); int_end = '0;
        check("multi_idle", inflight, '0);

        // Reset mid-WAIT: source 9 with cnt=2, source 20 held high through reset
        goto(120); irq_src[9] = 1'b1; expect_pulse(122, bitv(9));
        goto(121); irq_src[9] = 1'b0;
        goto(124); irq_src[9] = 1'b1;
        goto(125); irq_src[9] = 1'b0;
        goto(126); irq_src[9] = 1'b1;
        goto(127); irq_src[9] = 1'b0;
        goto(130); check("pre_reset_wait", inflight, bitv(9));
        goto(131); rstn = 1'b0; irq_src[20] = 1'b1;
        goto(132); rstn = 1'b1; expect_pulse(134, bitv(20));
        check("midreset_pack", int_req_pack, '0);
        check("midreset_inflight", inflight, '0);
        goto(140); int_end[9] = 1'b1;
        goto(141); int_end[9] = 1'b0;
        check("post_reset_end_ignored", inflight, bitv(20));
        goto(150); int_end[20] = 1'b1;
        goto(151); int_end[20] = 1'b0;
        check("held_line_idle", inflight, '0);

        goto(160);
        check("scoreboard_empty", NSRC'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway feeding the PLIC core. It synchronizes raw interrupt lines, converts level or edge events into single-cycle request packets, and drives `int_req_pack` and `gateway_notif` into the core. It accepts the core's per-source `int_end` completion pulses and blocks each source from re-requesting until its completion arrives. Source 0 is reserved and never requests.

## Interface
- `NSRC`, default 128: number of interrupt sources. Must be 128 to match the core's packing.
- `SYNC_STAGES`, default 2: synchronizer flops per source, minimum 2.
- `EDGE_CNT_W`, default 2: width of the per-source saturating counter of queued edges.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `irq_src`  in  NSRC  raw, asynchronous interrupt lines, active-high.
- `edge_sel`  in  NSRC  per-source trigger mode; 1 = rising edge, 0 = level-high. Quasi-static.
- `int_end`  in  NSRC  completion pulses from the core, one cycle per claimed ID.
- `int_req_pack`  out  NSRC  request bits for this cycle. Bit i corresponds to source i.
- `gateway_notif`  out  1  high in exactly the cycles where `int_req_pack` is nonzero.
- `inflight`  out  NSRC  per-source WAIT-state flag, for status and debug.

## Operation
- **Synchronizer.** Each `irq_src[i]` passes through `SYNC_STAGES` flops, giving `s[i]`. One further flop `p[i]` holds the previous `s[i]`. The trigger `t[i]` is:
  - level mode: `s[i]`
  - edge mode: `s[i] & ~p[i]`
- **Per-source FSM, two states:**
  - IDLE, no request outstanding.
  - WAIT, request issued, awaiting `int_end[i]`.
- **Transitions:**
  - IDLE and `t[i]`: register `int_req_pack[i]=1` for one cycle, then go to WAIT.
  - WAIT and no `int_end[i]`:
    - Stay in WAIT.
    - In edge mode, `t[i]` increments `cnt[i]`, saturating at 2^EDGE_CNT_W-1. Any further edges are dropped.
  - WAIT and `int_end[i]`, level mode:
    - If `s[i]` is high, issue a new request pulse and stay in WAIT.
    - Otherwise go to IDLE.
  - WAIT and `int_end[i]`, edge mode:
    - If `cnt[i]>0`, issue a pulse, decrement `cnt[i]` and stay in WAIT. A simultaneous `t[i]` still increments, so the net count is unchanged.
    - Else if `t[i]`, issue a pulse and stay in WAIT.
    - Otherwise go to IDLE.
  - `int_end[i]` while IDLE is ignored.
- **Outputs and mode handling:**
  - `gateway_notif` is the registered OR of all request bits issued in the same update. Several sources may request in one cycle.
  - `cnt[i]` is forced to 0 whenever `edge_sel[i]=0`.
  - A mode change takes effect at the source's next decision. It never aborts WAIT.
- **Source 0:**
  - `int_req_pack[0]` is constant 0.
  - Its FSM is held in IDLE.
  - `inflight[0]` is 0.
- **Reset (rstn=0 at a clock edge):**
  - Synchronizer flops, `p`, `cnt` and all FSMs clear to IDLE.
  - `int_req_pack`, `gateway_notif` and `inflight` are all 0.
  - Because `p` resets to 0, an edge-mode line held high through reset registers exactly one edge after release.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **Request latency.** `irq_src[i]` is high and sampled at edge N, with the source IDLE. `int_req_pack[i]` and `gateway_notif` are then high for exactly one cycle, starting after edge N+SYNC_STAGES.
- **Completion latency.** When `int_end[i]` is high at edge M and a re-request is due, the new pulse is driven after edge M. Otherwise `inflight[i]` falls after edge M.
- **Minimum spacing.** Two pulses on one source are at least one completion apart. There are never back-to-back pulses without an intervening `int_end[i]`.
- **Core capture.** The core latches `pending |= int_req_pack` on `gateway_notif`, so a pulse is never held longer than one cycle.
- **Edge width.** Edge mode requires a raw high of at least 1 cycle and a low of at least 1 cycle between edges. Narrower glitches are not guaranteed to be seen.
- **Reset mid-operation.** Outstanding WAIT states and queued counts are discarded. Any `int_end` arriving after reset finds IDLE and is ignored.

## Test plan
- **Level request and clear.** Source 5, level mode: raise `irq_src[5]` at edge 10 → `int_req_pack=1<<5` and `gateway_notif=1` for exactly the cycle after edge 12; `inflight[5]=1`. Drop the line, pulse `int_end[5]` at edge 20 → `inflight[5]=0` after edge 20, no new pulse.
- **Level re-request.** Same as above but keep `irq_src[5]` high through `int_end[5]` at edge 20 → one new pulse on bit 5 after edge 20; `inflight[5]` stays 1.
- **Edge queuing.** Source 40, edge mode: 5 rising edges while in WAIT → `cnt` saturates at 3. Then 4 `int_end[40]` pulses, spaced 4 cycles apart → 3 re-request pulses follow the first three ends. After the fourth end, `inflight[40]=0`.
- **Simultaneous sources and source 0.** Raise sources 0, 1, 127 and 64 in the same cycle → a single `gateway_notif` cycle with `int_req_pack` = bits {1, 64, 127}; bit 0 is never set.
- **Reset mid-WAIT.** Source 9 in WAIT with `cnt=2`; assert `rstn=0` for one edge → all outputs 0. A subsequent `int_end[9]` produces no pulse. An edge-mode line held high through reset gives one pulse SYNC_STAGES cycles after release.
